// File: rtl/sq_desc_parser.sv
// AXI-Stream slave that unpacks a 16-beat SQ descriptor into rdma_* fields.
// It holds the parsed entry with a level valid, and flags and discards malformed frames.
module sq_desc_parser #(
    parameter int DESC_BEATS = 16,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic                 entry_clear,
    output logic [31:0]          rdma_id,
    output logic [15:0]          rdma_opcode,
    output logic [15:0]          rdma_flags,
    output logic [63:0]          rdma_local_key,
    output logic [63:0]          rdma_remote_key,
    output logic [127:0]         rdma_btt,
    output logic                 rdma_entry_valid,
    output logic                 parse_error,
    output logic [31:0]          desc_count,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam int         FIELD_WORDS = 10;
    localparam logic [3:0] LAST_BEAT   = 4'(DESC_BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_HOLD} state_t;

    state_t                        state_q;
    logic [3:0]                    beat_cnt_q;
    logic [FIELD_WORDS-1:0][31:0]  buf_q;
    logic [FIELD_WORDS-1:0][31:0]  shd_q;
    logic                          tready_q, valid_q, perr_q;
    logic [31:0]                   desc_cnt_q;
    logic [ERR_CNT_W-1:0]          err_cnt_q;
    logic                          accept, frame_ok, frame_err, at_last;

    assign accept   = s_axis_tvalid && tready_q;
    assign at_last  = (beat_cnt_q == LAST_BEAT);
    assign frame_ok = accept && (state_q == S_COLLECT) && s_axis_tlast && at_last;
    // A tlast on a frame's first beat (from IDLE or HOLD) is as malformed as a short or long frame.
    assign frame_err = accept && (
        (s_axis_tlast && (state_q == S_IDLE || state_q == S_HOLD)) ||
        ((state_q == S_COLLECT) && (s_axis_tlast != at_last)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= 4'd0;
            buf_q      <= '0;
            shd_q      <= '0;
            tready_q   <= 1'b0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            desc_cnt_q <= 32'd0;
            err_cnt_q  <= '0;
        end else begin
            tready_q <= 1'b1;
            perr_q   <= frame_err;
            if (frame_err && (err_cnt_q != {ERR_CNT_W{1'b1}}))
                err_cnt_q <= err_cnt_q + 1'b1;
            if (frame_ok)
                desc_cnt_q <= desc_cnt_q + 32'd1;

            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (accept) begin
                        valid_q    <= 1'b0;
                        buf_q[0]   <= s_axis_tdata;
                        beat_cnt_q <= 4'd1;
                        state_q    <= s_axis_tlast ? S_IDLE : S_COLLECT;
                    end else if (state_q == S_HOLD && entry_clear) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        if (beat_cnt_q < 4'(FIELD_WORDS))
                            buf_q[beat_cnt_q] <= s_axis_tdata;
                        beat_cnt_q <= beat_cnt_q + 4'd1;
                        if (frame_ok) begin
                            // Word 15 carries no field, so the buffer is complete here.
                            shd_q   <= buf_q;
                            valid_q <= 1'b1;
                            state_q <= S_HOLD;
                        end else if (s_axis_tlast) begin
                            state_q <= S_IDLE;
                        end else if (at_last) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (accept && s_axis_tlast)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_axis_tready    = tready_q;
    assign rdma_id          = shd_q[0];
    assign rdma_opcode      = shd_q[1][15:0];
    assign rdma_flags       = shd_q[1][31:16];
    assign rdma_local_key   = {shd_q[3], shd_q[2]};
    assign rdma_remote_key  = {shd_q[5], shd_q[4]};
    assign rdma_btt         = {shd_q[9], shd_q[8], shd_q[7], shd_q[6]};
    assign rdma_entry_valid = valid_q;
    assign parse_error      = perr_q;
    assign desc_count       = desc_cnt_q;
    assign err_count        = err_cnt_q;
endmodule

// File: tb/tb_sq_desc_parser.sv
// Directed bench for sq_desc_parser: good frames, short/long frames, back-to-back, reset, saturation.
module tb_sq_desc_parser;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast = 1'b0;
    logic         entry_clear = 1'b0;
    logic [31:0]  rdma_id;
    logic [15:0]  rdma_opcode, rdma_flags;
    logic [63:0]  rdma_local_key, rdma_remote_key;
    logic [127:0] rdma_btt;
    logic         rdma_entry_valid, parse_error;
    logic [31:0]  desc_count;
    logic [15:0]  err_count;

    int n_vec = 0;
    int n_err = 0;
    int perr_seen = 0;
    int tready_low = 0;

    sq_desc_parser #(.DESC_BEATS(16), .ERR_CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .entry_clear(entry_clear),
        .rdma_id(rdma_id), .rdma_opcode(rdma_opcode), .rdma_flags(rdma_flags),
        .rdma_local_key(rdma_local_key), .rdma_remote_key(rdma_remote_key),
        .rdma_btt(rdma_btt), .rdma_entry_valid(rdma_entry_valid),
        .parse_error(parse_error), .desc_count(desc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && parse_error) perr_seen++;
        if (!rst && s_axis_tvalid && !s_axis_tready) tready_low++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        @(negedge clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic frame(input logic [31:0] base, input int nbeats, input int last_at);
        for (int k = 0; k < nbeats; k++) beat(base + 32'(k), k == last_at);
        idle();
    endtask

    task automatic clear_entry();
        @(negedge clk);
        entry_clear = 1'b1;
        @(negedge clk);
        entry_clear = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_valid", rdma_entry_valid, 0);
        chk("rst_id", rdma_id, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_tready", s_axis_tready, 1);

        // 1: good frame
        frame(32'h1000_0000, 16, 15);
        chk("t1_valid", rdma_entry_valid, 1);
        chk("t1_id", rdma_id, 32'h1000_0000);
        chk("t1_opcode", rdma_opcode, 16'h0001);
        chk("t1_flags", rdma_flags, 16'h1000);
        chk("t1_lkey", rdma_local_key, 64'h10000003_10000002);
        chk("t1_rkey", rdma_remote_key, 64'h10000005_10000004);
        chk("t1_btt", rdma_btt, 128'h10000009_10000008_10000007_10000006);
        chk("t1_dcnt", desc_count, 1);
        chk("t1_perr", parse_error, 0);

        // 2: entry_clear, then second frame
        clear_entry();
        chk("t2_valid_clr", rdma_entry_valid, 0);
        chk("t2_id_held", rdma_id, 32'h1000_0000);
        frame(32'h2000_0000, 16, 15);
        chk("t2_valid", rdma_entry_valid, 1);
        chk("t2_id", rdma_id, 32'h2000_0000);
        chk("t2_dcnt", desc_count, 2);

        // 3: short frame, tlast on beat 7
        clear_entry();
        frame(32'h3000_0000, 8, 7);
        chk("t3_perr", parse_error, 1);
        chk("t3_ecnt", err_count, 1);
        chk("t3_valid", rdma_entry_valid, 0);
        chk("t3_id_kept", rdma_id, 32'h2000_0000);
        chk("t3_btt_kept", rdma_btt, 128'h20000009_20000008_20000007_20000006);
        @(negedge clk);
        chk("t3_perr_pulse", parse_error, 0);

        // 4: 20-beat frame, then good frame
        frame(32'h4000_0000, 20, 19);
        chk("t4_perr_seen", perr_seen, 2);
        chk("t4_ecnt", err_count, 2);
        chk("t4_valid", rdma_entry_valid, 0);
        frame(32'h5000_0000, 16, 15);
        chk("t4_valid_good", rdma_entry_valid, 1);
        chk("t4_id", rdma_id, 32'h5000_0000);
        chk("t4_opcode", rdma_opcode, 16'h0001);
        chk("t4_dcnt", desc_count, 3);
        chk("t4_ecnt_after", err_count, 2);

        // 5: back-to-back frames from a held entry, tvalid never dropped
        tready_low = 0;
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            if (j == 16) begin
                chk("t5_valid_a", rdma_entry_valid, 1);
                chk("t5_id_a", rdma_id, 32'h6000_0000);
            end
            if (j == 17) begin
                chk("t5_valid_drop", rdma_entry_valid, 0);
                chk("t5_id_hold", rdma_id, 32'h6000_0000);
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = (j < 16 ? 32'h6000_0000 : 32'h7000_0000) + 32'(j % 16);
            s_axis_tlast  = (j % 16) == 15;
            @(posedge clk);
        end
        idle();
        chk("t5_valid_b", rdma_entry_valid, 1);
        chk("t5_id_b", rdma_id, 32'h7000_0000);
        chk("t5_lkey_b", rdma_local_key, 64'h70000003_70000002);
        chk("t5_dcnt", desc_count, 5);
        chk("t5_tready_low", tready_low, 0);

        // 6: reset mid-frame
        for (int k = 0; k < 9; k++) beat(32'h8000_0000 + 32'(k), 1'b0);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_rst_tready", s_axis_tready, 0);
        chk("t6_rst_valid", rdma_entry_valid, 0);
        chk("t6_rst_id", rdma_id, 0);
        chk("t6_rst_btt", rdma_btt, 0);
        chk("t6_rst_dcnt", desc_count, 0);
        chk("t6_rst_ecnt", err_count, 0);
        chk("t6_rst_perr", parse_error, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_no_valid", rdma_entry_valid, 0);
        frame(32'h9000_0000, 16, 15);
        chk("t6_valid", rdma_entry_valid, 1);
        chk("t6_id", rdma_id, 32'h9000_0000);
        chk("t6_dcnt", desc_count, 1);
        chk("t6_ecnt", err_count, 0);

        // err_count saturation with single-beat malformed frames
        clear_entry();
        @(negedge clk);
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        s_axis_tdata  = 32'hDEAD_BEEF;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("sat_fffe", err_count, 16'hFFFE);
        repeat (3) @(posedge clk);
        idle();
        chk("sat_ffff", err_count, 16'hFFFF);
        repeat (2) @(negedge clk);
        chk("sat_hold", err_count, 16'hFFFF);
        chk("sat_valid", rdma_entry_valid, 0);
        chk("sat_id_kept", rdma_id, 32'h9000_0000);
        chk("sat_dcnt", desc_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
